// File: rtl/cpu_core.sv
// Parametrised accumulator CPU: A/B registers, PC, opcode register and {C,Z} flags,
// fetching instructions and operands over a req/ready read port that tolerates wait states.
module cpu_core #(
   parameter int                DATA_W   = 8,
   parameter int                ADDR_W   = 8,
   parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic [DATA_W-1:0] a_out,
   output logic [DATA_W-1:0] b_out,
   output logic [ADDR_W-1:0] pc_out,
   output logic [1:0]        flags,
   output logic              retire,
   output logic              halted
);

   typedef enum logic [1:0] {
      ST_FETCH   = 2'd0,
      ST_DECODE  = 2'd1,
      ST_OPERAND = 2'd2,
      ST_HALT    = 2'd3
   } state_t;

   localparam logic [3:0] OP_LDA  = 4'h0;
   localparam logic [3:0] OP_LDB  = 4'h1;
   localparam logic [3:0] OP_ADDI = 4'h2;
   localparam logic [3:0] OP_ADDB = 4'h3;
   localparam logic [3:0] OP_SUBI = 4'h4;
   localparam logic [3:0] OP_SUBB = 4'h5;
   localparam logic [3:0] OP_JMP  = 4'h6;
   localparam logic [3:0] OP_JZ   = 4'h7;
   localparam logic [3:0] OP_JC   = 4'h8;
   localparam logic [3:0] OP_HLT  = 4'h9;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [3:0]        ir_q, ir_d;
   logic              z_q, z_d, c_q, c_d;
   logic              retire_q, retire_d;
   logic              mem_req_q, mem_req_d;
   logic              halted_q, halted_d;
   logic [ADDR_W-1:0] pc_inc_s;
   logic [ADDR_W-1:0] jmp_tgt_s;
   logic [DATA_W:0]   alu_s;

   // Bit DATA_W of the result is the carry for ADD and the borrow for SUB.
   function automatic logic [DATA_W:0] alu_f(input logic [DATA_W-1:0] lhs,
                                             input logic [DATA_W-1:0] rhs,
                                             input logic              sub);
      if (sub) begin
         return {1'b0, lhs} - {1'b0, rhs};
      end else begin
         return {1'b0, lhs} + {1'b0, rhs};
      end
   endfunction

   assign pc_inc_s = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};

   if (ADDR_W > DATA_W) begin : g_tgt_ext
      assign jmp_tgt_s = {{(ADDR_W-DATA_W){1'b0}}, mem_rdata};
   end else begin : g_tgt_trunc
      assign jmp_tgt_s = mem_rdata[ADDR_W-1:0];
   end

   // Next-state and datapath update logic.
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      pc_d     = pc_q;
      ir_d     = ir_q;
      z_d      = z_q;
      c_d      = c_q;
      retire_d = 1'b0;
      alu_s    = {(DATA_W+1){1'b0}};
      case (state_q)
         ST_FETCH: begin
            if (mem_req_q && mem_ready) begin
               ir_d    = mem_rdata[3:0];
               pc_d    = pc_inc_s;
               state_d = ST_DECODE;
            end else begin
               state_d = ST_FETCH;
            end
         end
         ST_DECODE: begin
            case (ir_q)
               OP_LDA, OP_LDB, OP_ADDI, OP_SUBI, OP_JMP, OP_JZ, OP_JC: begin
                  state_d = ST_OPERAND;
               end
               OP_ADDB, OP_SUBB: begin
                  alu_s    = alu_f(a_q, b_q, ir_q == OP_SUBB);
                  a_d      = alu_s[DATA_W-1:0];
                  c_d      = alu_s[DATA_W];
                  z_d      = (alu_s[DATA_W-1:0] == {DATA_W{1'b0}});
                  retire_d = 1'b1;
                  state_d  = ST_FETCH;
               end
               OP_HLT: begin
                  retire_d = 1'b1;
                  state_d  = ST_HALT;
               end
               default: begin
                  retire_d = 1'b1;
                  state_d  = ST_FETCH;
               end
            endcase
         end
         ST_OPERAND: begin
            if (mem_req_q && mem_ready) begin
               pc_d     = pc_inc_s;
               retire_d = 1'b1;
               state_d  = ST_FETCH;
               case (ir_q)
                  OP_LDA: a_d = mem_rdata;
                  OP_LDB: b_d = mem_rdata;
                  OP_ADDI, OP_SUBI: begin
                     alu_s = alu_f(a_q, mem_rdata, ir_q == OP_SUBI);
                     a_d   = alu_s[DATA_W-1:0];
                     c_d   = alu_s[DATA_W];
                     z_d   = (alu_s[DATA_W-1:0] == {DATA_W{1'b0}});
                  end
                  OP_JMP: pc_d = jmp_tgt_s;
                  OP_JZ:  pc_d = z_q ? jmp_tgt_s : pc_inc_s;
                  OP_JC:  pc_d = c_q ? jmp_tgt_s : pc_inc_s;
                  default: pc_d = pc_inc_s;
               endcase
            end else begin
               state_d = ST_OPERAND;
            end
         end
         ST_HALT: begin
            state_d = ST_HALT;
         end
         default: begin
            state_d = ST_FETCH;
         end
      endcase
   end

   // Request and halt flags are registered from the next state, so reset forces them low.
   always_comb begin
      mem_req_d = (state_d == ST_FETCH) || (state_d == ST_OPERAND);
      halted_d  = (state_d == ST_HALT);
   end

   // State and architectural registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_FETCH;
         a_q       <= {DATA_W{1'b0}};
         b_q       <= {DATA_W{1'b0}};
         pc_q      <= RESET_PC;
         ir_q      <= 4'h0;
         z_q       <= 1'b0;
         c_q       <= 1'b0;
         retire_q  <= 1'b0;
         mem_req_q <= 1'b0;
         halted_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         z_q       <= z_d;
         c_q       <= c_d;
         retire_q  <= retire_d;
         mem_req_q <= mem_req_d;
         halted_q  <= halted_d;
      end
   end

   assign mem_req  = mem_req_q;
   assign mem_addr = pc_q;
   assign a_out    = a_q;
   assign b_out    = b_q;
   assign pc_out   = pc_q;
   assign flags    = {c_q, z_q};
   assign retire   = retire_q;
   assign halted   = halted_q;

endmodule

// File: tb/tb_cpu_core.sv
// Scoreboard bench for cpu_core: 8-bit and 16-bit/4-bit-address instances, directed programs,
// expected register state per retired instruction queued up front and checked on each retire pulse.
module tb_cpu_core;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst8_n, rst16_n;
   logic        m8_req, m8_ready, ret8, hlt8;
   logic [7:0]  m8_addr, m8_rdata, a8, b8, pc8;
   logic [1:0]  f8;
   logic        m16_req, m16_ready, ret16, hlt16;
   logic [3:0]  m16_addr, pc16;
   logic [15:0] m16_rdata, a16, b16;
   logic [1:0]  f16;

   logic [7:0]  mem8  [256];
   logic [15:0] mem16 [16];
   assign m8_rdata  = mem8[m8_addr];
   assign m16_rdata = mem16[m16_addr];

   cpu_core dut8 (
      .clk(clk), .rst_n(rst8_n), .mem_req(m8_req), .mem_addr(m8_addr),
      .mem_rdata(m8_rdata), .mem_ready(m8_ready), .a_out(a8), .b_out(b8),
      .pc_out(pc8), .flags(f8), .retire(ret8), .halted(hlt8)
   );

   cpu_core #(.DATA_W(16), .ADDR_W(4)) dut16 (
      .clk(clk), .rst_n(rst16_n), .mem_req(m16_req), .mem_addr(m16_addr),
      .mem_rdata(m16_rdata), .mem_ready(m16_ready), .a_out(a16), .b_out(b16),
      .pc_out(pc16), .flags(f16), .retire(ret16), .halted(hlt16)
   );

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [7:0]  pc;
      logic [1:0]  f;
   } exp_t;

   exp_t q8[$];
   exp_t q16[$];
   int   tests = 0;
   int   fails = 0;
   int   ret_cnt8 = 0;
   int   waits8 = 0;
   bit   noise8 = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic exp_t mk(input logic [15:0] a, input logic [15:0] b,
                               input logic [7:0] pc, input logic [1:0] f);
      exp_t e;
      e.a = a; e.b = b; e.pc = pc; e.f = f;
      return e;
   endfunction

   // memory model for dut8: programmable wait states, optional idle-ready noise, hold check
   initial begin
      int          cnt;
      bit          pend;
      logic [7:0]  paddr;
      cnt = 0; pend = 1'b0; paddr = 8'h00; m8_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (pend && rst8_n) check("dut8_req_hold", 64'({m8_req, m8_addr}), 64'({1'b1, paddr}));
         if (m8_req && rst8_n) begin
            if (cnt >= waits8) begin
               m8_ready = 1'b1; cnt = 0; pend = 1'b0;
            end else begin
               m8_ready = 1'b0; cnt++; pend = 1'b1; paddr = m8_addr;
            end
         end else begin
            m8_ready = noise8; cnt = 0; pend = 1'b0;
         end
      end
   end

   initial m16_ready = 1'b1;

   // retire monitors
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst8_n && ret8) begin
            ret_cnt8++;
            if (q8.size() == 0) begin
               tests++; fails++;
               $display("FAIL dut8_retire: unexpected retire at pc=0x%0h", pc8);
            end else begin
               e = q8.pop_front();
               check("dut8_retire{a,b,pc,f}", 64'({a8, b8, pc8, f8}),
                     64'({e.a[7:0], e.b[7:0], e.pc, e.f}));
            end
         end
      end
   end

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst16_n && ret16) begin
            if (q16.size() == 0) begin
               tests++; fails++;
               $display("FAIL dut16_retire: unexpected retire at pc=0x%0h", pc16);
            end else begin
               e = q16.pop_front();
               check("dut16_retire{a,b,pc,f}", 64'({a16, b16, pc16, f16}),
                     64'({e.a, e.b, e.pc[3:0], e.f}));
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic fill8();
      for (int i = 0; i < 256; i++) mem8[i] = 8'h09;
   endtask

   task automatic start8();
      @(negedge clk);
      rst8_n = 1'b0;
      @(negedge clk);
      rst8_n = 1'b1;
   endtask

   // counts cycles from first mem_req to first retire and to halted
   task automatic measure8(input int budget, output int t_ret, output int t_halt);
      int c;
      c = 0; t_ret = -1; t_halt = -1;
      while (!m8_req && c < budget) begin
         @(negedge clk); c++;
      end
      if (!m8_req) begin
         tests++; fails++;
         $display("FAIL dut8_req_timeout: mem_req 0, expected 1");
         return;
      end
      c = 0;
      while (!hlt8 && c < budget) begin
         @(negedge clk); c++;
         if (ret8 && t_ret < 0) t_ret = c;
      end
      t_halt = hlt8 ? c : -1;
   endtask

   task automatic load_prog1();
      fill8();
      mem8[0] = 8'h00; mem8[1] = 8'h05; mem8[2] = 8'h01; mem8[3] = 8'h03;
      mem8[4] = 8'h03; mem8[5] = 8'h09;
      q8.push_back(mk(16'h05, 16'h00, 8'h02, 2'b00));
      q8.push_back(mk(16'h05, 16'h03, 8'h04, 2'b00));
      q8.push_back(mk(16'h08, 16'h03, 8'h05, 2'b00));
      q8.push_back(mk(16'h08, 16'h03, 8'h06, 2'b00));
   endtask

   initial begin
      int t_ret, t_halt, c;
      rst8_n = 1'b0; rst16_n = 1'b0;
      fill8();
      for (int i = 0; i < 16; i++) mem16[i] = 16'h0009;
      repeat (3) @(negedge clk);
      check("reset_ctrl8{req,retire,halted}", 64'({m8_req, ret8, hlt8}), 64'(3'b000));
      check("reset_regs8{a,b,pc,f}", 64'({a8, b8, pc8, f8}), 64'(26'h0));
      check("reset16{req,a,b,pc,f,halted}", 64'({m16_req, a16, b16, pc16, f16, hlt16}), 64'(40'h0));

      // zero-wait LDA 5; LDB 3; ADDB; HLT
      load_prog1();
      ret_cnt8 = 0;
      start8();
      measure8(100, t_ret, t_halt);
      check("p1_lda_cycles", 64'(t_ret), 64'(3));
      check("p1_halt_cycles", 64'(t_halt), 64'(10));
      repeat (3) @(negedge clk);
      check("p1_retire_count", 64'(ret_cnt8), 64'(4));
      check("p1_idle{req,halted}", 64'({m8_req, hlt8}), 64'(2'b01));
      check("p1_queue_empty", 64'(q8.size()), 64'(0));

      // carry/zero then taken JZ
      fill8();
      mem8[0] = 8'h00; mem8[1] = 8'hFF; mem8[2] = 8'h02; mem8[3] = 8'h01;
      mem8[4] = 8'h07; mem8[5] = 8'h20;
      q8.push_back(mk(16'hFF, 16'h00, 8'h02, 2'b00));
      q8.push_back(mk(16'h00, 16'h00, 8'h04, 2'b11));
      q8.push_back(mk(16'h00, 16'h00, 8'h20, 2'b11));
      q8.push_back(mk(16'h00, 16'h00, 8'h21, 2'b11));
      start8();
      measure8(100, t_ret, t_halt);
      check("p2a_halted", 64'(hlt8), 64'(1));

      // untaken JZ and JC
      fill8();
      mem8[0] = 8'h00; mem8[1] = 8'h01; mem8[2] = 8'h02; mem8[3] = 8'h01;
      mem8[4] = 8'h07; mem8[5] = 8'h20; mem8[6] = 8'h08; mem8[7] = 8'h30;
      q8.push_back(mk(16'h01, 16'h00, 8'h02, 2'b00));
      q8.push_back(mk(16'h02, 16'h00, 8'h04, 2'b00));
      q8.push_back(mk(16'h02, 16'h00, 8'h06, 2'b00));
      q8.push_back(mk(16'h02, 16'h00, 8'h08, 2'b00));
      q8.push_back(mk(16'h02, 16'h00, 8'h09, 2'b00));
      start8();
      measure8(100, t_ret, t_halt);
      check("p2b_halted", 64'(hlt8), 64'(1));

      // borrow, taken JC, SUBB to zero, JMP, NOP; ready noise while idle
      fill8();
      noise8 = 1'b1;
      mem8[8'h00] = 8'h00; mem8[8'h01] = 8'h03; mem8[8'h02] = 8'h04; mem8[8'h03] = 8'h05;
      mem8[8'h04] = 8'h08; mem8[8'h05] = 8'h10;
      mem8[8'h10] = 8'h00; mem8[8'h11] = 8'h05; mem8[8'h12] = 8'h01; mem8[8'h13] = 8'h05;
      mem8[8'h14] = 8'h05; mem8[8'h15] = 8'h06; mem8[8'h16] = 8'h40;
      mem8[8'h40] = 8'h0F; mem8[8'h41] = 8'h09;
      q8.push_back(mk(16'h03, 16'h00, 8'h02, 2'b00));
      q8.push_back(mk(16'hFE, 16'h00, 8'h04, 2'b10));
      q8.push_back(mk(16'hFE, 16'h00, 8'h10, 2'b10));
      q8.push_back(mk(16'h05, 16'h00, 8'h12, 2'b10));
      q8.push_back(mk(16'h05, 16'h05, 8'h14, 2'b10));
      q8.push_back(mk(16'h00, 16'h05, 8'h15, 2'b01));
      q8.push_back(mk(16'h00, 16'h05, 8'h40, 2'b01));
      q8.push_back(mk(16'h00, 16'h05, 8'h41, 2'b01));
      q8.push_back(mk(16'h00, 16'h05, 8'h42, 2'b01));
      start8();
      measure8(200, t_ret, t_halt);
      check("p3_halted", 64'(hlt8), 64'(1));
      noise8 = 1'b0;

      // three wait states on every request
      waits8 = 3;
      load_prog1();
      start8();
      measure8(200, t_ret, t_halt);
      check("p4_lda_cycles", 64'(t_ret), 64'(9));
      check("p4_halt_cycles", 64'(t_halt), 64'(28));
      check("p4_final{a,b,f}", 64'({a8, b8, f8}), 64'({8'h08, 8'h03, 2'b00}));

      // reset while the second LDA waits for its operand
      fill8();
      mem8[0] = 8'h00; mem8[1] = 8'h11; mem8[2] = 8'h00; mem8[3] = 8'h77; mem8[4] = 8'h09;
      q8.push_back(mk(16'h11, 16'h00, 8'h02, 2'b00));
      q8.push_back(mk(16'h11, 16'h00, 8'h02, 2'b00));
      q8.push_back(mk(16'h77, 16'h00, 8'h04, 2'b00));
      q8.push_back(mk(16'h77, 16'h00, 8'h05, 2'b00));
      start8();
      c = 0;
      while (!(m8_req && m8_addr == 8'h03) && c < 100) begin
         @(negedge clk); c++;
      end
      check("p6_reached_operand{req,addr}", 64'({m8_req, m8_addr}), 64'({1'b1, 8'h03}));
      @(posedge clk); #2;
      rst8_n = 1'b0;
      #1;
      check("p6_rst_ctrl{req,retire,halted}", 64'({m8_req, ret8, hlt8}), 64'(3'b000));
      check("p6_rst_regs{a,b,pc,f}", 64'({a8, b8, pc8, f8}), 64'(26'h0));
      @(posedge clk); #2;
      check("p6_held_a", 64'(a8), 64'(0));
      rst8_n = 1'b1;
      measure8(200, t_ret, t_halt);
      check("p6_halted", 64'(hlt8), 64'(1));
      check("p6_queue_empty", 64'(q8.size()), 64'(0));

      // 16-bit data, 4-bit address: carry out of bit 15 and PC wrap
      mem16[4'h0] = 16'h0000; mem16[4'h1] = 16'h0001; mem16[4'h2] = 16'h0002;
      mem16[4'h3] = 16'hFFFF; mem16[4'h4] = 16'h0006; mem16[4'h5] = 16'h000F;
      mem16[4'hF] = 16'h00AF;
      q16.push_back(mk(16'h0001, 16'h0000, 8'h02, 2'b00));
      q16.push_back(mk(16'h0000, 16'h0000, 8'h04, 2'b11));
      q16.push_back(mk(16'h0000, 16'h0000, 8'h0F, 2'b11));
      q16.push_back(mk(16'h0000, 16'h0000, 8'h00, 2'b11));
      @(negedge clk);
      rst16_n = 1'b1;
      c = 0;
      while (q16.size() != 0 && c < 100) begin
         @(negedge clk); c++;
      end
      check("w16_all_retired", 64'(q16.size()), 64'(0));
      @(posedge clk); #2;
      rst16_n = 1'b0;
      repeat (2) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
